// File: rtl/mpu_load_sched.sv
// Load scheduler for the matrix unit: queues load commands, issues them one at a time
// to the load unit, and tracks which matrix registers hold live data.

package global_defs;
  localparam int MATRIX_REG_SIZE = 3;
  localparam int MBITS           = 3;
  localparam int NBITS           = 3;
  localparam int M               = 2**MBITS;
  localparam int N               = 2**NBITS;
endpackage

// One busy flag per matrix register; a set in the same cycle as a clear wins.
module mpu_busy_cell (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic busy
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      busy <= 1'b0;
    else if (set)  busy <= 1'b1;
    else if (clr)  busy <= 1'b0;
  end
endmodule

module mpu_load_sched
  import global_defs::*;
#(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 16,
  localparam int NREG   = 2**MATRIX_REG_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_in,
  output logic                       cmd_ready_out,
  input  logic [MATRIX_REG_SIZE-1:0] cmd_addr_in,
  input  logic [MBITS:0]             cmd_m_in,
  input  logic [NBITS:0]             cmd_n_in,
  output logic                       load_en_out,
  output logic [MATRIX_REG_SIZE-1:0] load_addr_out,
  output logic [MBITS:0]             load_m_out,
  output logic [NBITS:0]             load_n_out,
  input  logic                       load_ack_in,
  input  logic                       load_error_in,
  input  logic                       release_in,
  input  logic [MATRIX_REG_SIZE-1:0] release_addr_in,
  output logic [NREG-1:0]            busy_out,
  output logic                       done_valid_out,
  output logic [MATRIX_REG_SIZE-1:0] done_addr_out,
  output logic                       done_error_out
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = MBITS + NBITS + 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [MATRIX_REG_SIZE-1:0] addr;
    logic [MBITS:0]             m;
    logic [NBITS:0]             n;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_DONE} state_t;

  state_t        state;
  cmd_t          iss;
  logic          err_r;
  logic [TW-1:0] tmo_cnt;
  logic [CW-1:0] elem_cnt;

  // ---------------- command FIFO (extra pointer bit tells full from empty)
  cmd_t          fifo_q [QDEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  cmd_t          head, cmd_in;

  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign head   = fifo_q[rd_ptr[PW-1:0]];
  assign cmd_in = '{addr: cmd_addr_in, m: cmd_m_in, n: cmd_n_in};

  assign cmd_ready_out = ~full;
  assign push = cmd_valid_in & ~full;
  // Head-of-line blocking: a busy destination stalls the whole queue.
  assign pop  = (state == S_IDLE) & ~empty & ~busy_out[head.addr];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr[PW-1:0]] <= cmd_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- completion conditions
  logic [CW-1:0] mn;
  logic          tmo_hit, iss_fail, strm_end, strm_bad, err_done, active;

  assign mn       = CW'(iss.m) * CW'(iss.n);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
  assign iss_fail = (state == S_ISSUE) & (load_error_in | (~load_ack_in & tmo_hit));
  assign strm_end = (state == S_STREAM) & ~load_ack_in;
  assign strm_bad = (elem_cnt != mn);
  assign err_done = iss_fail | (strm_end & strm_bad);
  assign active   = (state == S_ISSUE) | (state == S_STREAM);

  // ---------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      iss      <= '0;
      err_r    <= 1'b0;
      tmo_cnt  <= '0;
      elem_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          iss     <= head;
          err_r   <= 1'b0;
          tmo_cnt <= '0;
          state   <= S_ISSUE;
        end
        S_ISSUE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (load_error_in) begin
            err_r <= 1'b1;
            state <= S_DONE;
          end else if (load_ack_in) begin
            elem_cnt <= CW'(1);
            state    <= S_STREAM;
          end else if (tmo_hit) begin
            err_r <= 1'b1;
            state <= S_DONE;
          end
        end
        S_STREAM: begin
          if (load_ack_in) elem_cnt <= elem_cnt + 1'b1;
          else begin
            err_r <= strm_bad;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- per-register busy tracking
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic hit_iss, set_g, clr_g;
    assign hit_iss = (iss.addr == MATRIX_REG_SIZE'(g));
    assign set_g   = pop & (head.addr == MATRIX_REG_SIZE'(g));
    // A release aimed at the in-flight register is dropped; failed loads free it.
    assign clr_g   = (err_done & hit_iss) |
                     (release_in & (release_addr_in == MATRIX_REG_SIZE'(g)) & ~(active & hit_iss));
    mpu_busy_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .set  (set_g),
      .clr  (clr_g),
      .busy (busy_out[g])
    );
  end

  // ---------------- outputs decoded from state and issue registers
  assign load_en_out    = (state == S_ISSUE);
  assign load_addr_out  = iss.addr;
  assign load_m_out     = iss.m;
  assign load_n_out     = iss.n;
  assign done_valid_out = (state == S_DONE);
  assign done_addr_out  = iss.addr;
  assign done_error_out = (state == S_DONE) & err_r;

endmodule

// File: tb/tb_mpu_load_sched.sv
// Directed bench for mpu_load_sched: hand-computed expectations, checked on the falling edge.
module tb_mpu_load_sched;
  import global_defs::*;

  localparam int NREG = 2**MATRIX_REG_SIZE;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       cmd_valid_in;
  logic                       cmd_ready_out;
  logic [MATRIX_REG_SIZE-1:0] cmd_addr_in;
  logic [MBITS:0]             cmd_m_in;
  logic [NBITS:0]             cmd_n_in;
  logic                       load_en_out;
  logic [MATRIX_REG_SIZE-1:0] load_addr_out;
  logic [MBITS:0]             load_m_out;
  logic [NBITS:0]             load_n_out;
  logic                       load_ack_in;
  logic                       load_error_in;
  logic                       release_in;
  logic [MATRIX_REG_SIZE-1:0] release_addr_in;
  logic [NREG-1:0]            busy_out;
  logic                       done_valid_out;
  logic [MATRIX_REG_SIZE-1:0] done_addr_out;
  logic                       done_error_out;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mpu_load_sched #(.QDEPTH(4), .TIMEOUT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid_in    (cmd_valid_in),
    .cmd_ready_out   (cmd_ready_out),
    .cmd_addr_in     (cmd_addr_in),
    .cmd_m_in        (cmd_m_in),
    .cmd_n_in        (cmd_n_in),
    .load_en_out     (load_en_out),
    .load_addr_out   (load_addr_out),
    .load_m_out      (load_m_out),
    .load_n_out      (load_n_out),
    .load_ack_in     (load_ack_in),
    .load_error_in   (load_error_in),
    .release_in      (release_in),
    .release_addr_in (release_addr_in),
    .busy_out        (busy_out),
    .done_valid_out  (done_valid_out),
    .done_addr_out   (done_addr_out),
    .done_error_out  (done_error_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int a, input int m, input int n);
    cmd_valid_in = 1'b1;
    cmd_addr_in  = MATRIX_REG_SIZE'(a);
    cmd_m_in     = (MBITS+1)'(m);
    cmd_n_in     = (NBITS+1)'(n);
    @(negedge clk);
    cmd_valid_in = 1'b0;
  endtask

  task automatic rel(input int a);
    release_in      = 1'b1;
    release_addr_in = MATRIX_REG_SIZE'(a);
    @(negedge clk);
    release_in      = 1'b0;
  endtask

  task automatic wait_en(output int c);
    c = 0;
    while (load_en_out !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (done_valid_out !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  int c, w;
  int tm [5] = '{1, 1, 2, 2, 3};
  int tn [5] = '{1, 2, 1, 2, 1};

  initial begin
    rst = 1'b0;
    cmd_valid_in = 1'b0; cmd_addr_in = '0; cmd_m_in = '0; cmd_n_in = '0;
    load_ack_in = 1'b0; load_error_in = 1'b0;
    release_in = 1'b0; release_addr_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready_out), 1);
    chk("rst_en",    32'(load_en_out), 0);
    chk("rst_busy",  32'(busy_out), 0);
    chk("rst_done",  32'(done_valid_out), 0);
    chk("rst_err",   32'(done_error_out), 0);
    chk("rst_laddr", 32'(load_addr_out), 0);
    rst = 1'b1;
    @(negedge clk);

    // good load: 2x3, ack for 6 cycles starting in ISSUE
    push(1, 2, 3);
    wait_en(c);
    chk("t1_issue_lat", c, 1);
    chk("t1_laddr", 32'(load_addr_out), 1);
    chk("t1_lm",    32'(load_m_out), 2);
    chk("t1_ln",    32'(load_n_out), 3);
    chk("t1_busy",  32'(busy_out[1]), 1);
    load_ack_in = 1'b1;
    @(negedge clk);
    chk("t1_stream_en", 32'(load_en_out), 0);
    repeat (5) @(negedge clk);
    load_ack_in = 1'b0;
    wait_done(c);
    chk("t1_done_lat", c, 1);
    chk("t1_daddr", 32'(done_addr_out), 1);
    chk("t1_derr",  32'(done_error_out), 0);
    chk("t1_busy_done", 32'(busy_out[1]), 1);
    chk("t1_lm_hold", 32'(load_m_out), 2);
    @(negedge clk);
    chk("t1_pulse", 32'(done_valid_out), 0);

    // error in ISSUE, with ack in the same cycle: error wins, no stream
    push(2, 0, 3);
    wait_en(c);
    chk("t2_issue_lat", c, 1);
    load_error_in = 1'b1;
    load_ack_in   = 1'b1;
    @(negedge clk);
    load_error_in = 1'b0;
    load_ack_in   = 1'b0;
    chk("t2_done",  32'(done_valid_out), 1);
    chk("t2_derr",  32'(done_error_out), 1);
    chk("t2_daddr", 32'(done_addr_out), 2);
    chk("t2_busy",  32'(busy_out[2]), 0);
    @(negedge clk);
    chk("t2_idle_en", 32'(load_en_out), 0);

    // second load to a busy register waits for release
    push(1, 1, 1);
    repeat (3) @(negedge clk);
    chk("t3_blocked", 32'(load_en_out), 0);
    rel(1);
    chk("t3_busy_clr", 32'(busy_out[1]), 0);
    wait_en(c);
    chk("t3_issue_lat", c, 1);
    chk("t3_busy_set", 32'(busy_out[1]), 1);
    load_ack_in = 1'b1;
    @(negedge clk);
    load_ack_in = 1'b0;
    wait_done(c);
    chk("t3_derr", 32'(done_error_out), 0);
    @(negedge clk);

    // timeout; a release aimed at the in-flight register is ignored
    push(3, 2, 2);
    wait_en(c);
    chk("t4_issue_lat", c, 1);
    rel(3);
    chk("t4_rel_ignored", 32'(busy_out[3]), 1);
    wait_done(c);
    chk("t4_tmo_lat", c, 15);
    chk("t4_derr", 32'(done_error_out), 1);
    chk("t4_busy", 32'(busy_out[3]), 0);
    @(negedge clk);

    // fill FIFO behind a blocked head, then drain in order
    for (int i = 0; i < 5; i++) begin
      cmd_valid_in = 1'b1;
      cmd_addr_in  = MATRIX_REG_SIZE'(1);
      cmd_m_in     = (MBITS+1)'(tm[i]);
      cmd_n_in     = (NBITS+1)'(tn[i]);
      chk("t5_ready", 32'(cmd_ready_out), (i < 4) ? 1 : 0);
      if (i < 4) @(negedge clk);
    end
    chk("t5_head_blocked", 32'(load_en_out), 0);
    rel(1);
    w = 0;
    while (cmd_ready_out !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("t5_refill_lat", w, 1);
    @(negedge clk);
    cmd_valid_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) rel(1);
      wait_en(c);
      if (k > 0) chk("t5_issue_lat", c, 1);
      chk("t5_lm", 32'(load_m_out), 32'(tm[k]));
      chk("t5_ln", 32'(load_n_out), 32'(tn[k]));
      load_ack_in = 1'b1;
      repeat (tm[k] * tn[k]) @(negedge clk);
      load_ack_in = 1'b0;
      wait_done(c);
      chk("t5_done_lat", c, 1);
      chk("t5_derr", 32'(done_error_out), 0);
    end
    @(negedge clk);
    chk("t5_empty_ready", 32'(cmd_ready_out), 1);
    rel(1);
    repeat (3) @(negedge clk);
    chk("t5_no_dup", 32'(load_en_out), 0);

    // set and release of the same register in one cycle: set wins
    push(6, 1, 1);
    rel(6);
    chk("t6_set_wins", 32'(busy_out[6]), 1);
    chk("t6_en", 32'(load_en_out), 1);
    load_error_in = 1'b1;
    @(negedge clk);
    load_error_in = 1'b0;
    chk("t6_derr", 32'(done_error_out), 1);
    @(negedge clk);

    // short stream: 5 of 6 elements
    push(4, 2, 3);
    wait_en(c);
    load_ack_in = 1'b1;
    repeat (5) @(negedge clk);
    load_ack_in = 1'b0;
    wait_done(c);
    chk("t7_done_lat", c, 1);
    chk("t7_derr", 32'(done_error_out), 1);
    chk("t7_busy", 32'(busy_out[4]), 0);
    @(negedge clk);

    // reset mid-stream
    push(5, 3, 3);
    wait_en(c);
    load_ack_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("t8_streaming", 32'(load_en_out), 0);
    chk("t8_pre_busy", 32'(busy_out), 32'h20);
    rst = 1'b0;
    #1;
    chk("t8_busy",  32'(busy_out), 0);
    chk("t8_ready", 32'(cmd_ready_out), 1);
    chk("t8_laddr", 32'(load_addr_out), 0);
    chk("t8_lm",    32'(load_m_out), 0);
    chk("t8_done",  32'(done_valid_out), 0);
    load_ack_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t8_no_done", 32'(done_valid_out), 0);
    end
    chk("t8_idle_en", 32'(load_en_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mpu_load_sched.md
MPU_LOAD_SCHED -- requirements
Module: mpu_load_sched

Interface
REQ-001 Parameter QDEPTH, default 4, command FIFO depth (power of 2, >=2).
REQ-002 Parameter TIMEOUT, default 16, max cycles in ISSUE waiting for ack/error.
REQ-003 Widths MATRIX_REG_SIZE, MBITS, NBITS, M, N SHALL come from global_defs; NREG = 2**MATRIX_REG_SIZE.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid_in  in  1  load command offered.
REQ-007 cmd_ready_out  out  1  FIFO not full; command accepted when valid&ready.
REQ-008 cmd_addr_in  in  MATRIX_REG_SIZE  destination matrix register.
REQ-009 cmd_m_in / cmd_n_in  in  MBITS+1 / NBITS+1  matrix rows / columns.
REQ-010 load_en_out  out  1  start request to load unit.
REQ-011 load_addr_out, load_m_out, load_n_out  out  as cmd_*  held-stable parameters of issued command.
REQ-012 load_ack_in  in  1  load unit accepting/streaming elements.
REQ-013 load_error_in  in  1  load unit dimension error.
REQ-014 release_in  in  1  consumer frees register release_addr_in.
REQ-015 release_addr_in  in  MATRIX_REG_SIZE  register to free.
REQ-016 busy_out  out  NREG  per-register busy (loading or loaded, not released).
REQ-017 done_valid_out  out  1  one-cycle completion pulse.
REQ-018 done_addr_out  out  MATRIX_REG_SIZE  register of completed command.
REQ-019 done_error_out  out  1  qualifies done_valid_out: command failed.

Function
REQ-020 FIFO SHALL hold QDEPTH commands; push on cmd_valid_in&cmd_ready_out; simultaneous push and pop allowed when full-1 or empty-with-pop-blocked; pointers wrap modulo QDEPTH.
REQ-021 States: IDLE, ISSUE, STREAM, DONE; state register only, outputs decoded from state and registered fields.
REQ-022 IDLE: if FIFO non-empty and busy_out[head.addr]==0, pop head into issue registers, go ISSUE next cycle; else stay (head blocked, no reordering).
REQ-023 ISSUE: load_en_out=1; timeout counter increments each cycle.
REQ-024 ISSUE: load_error_in=1 -> DONE with error; else load_ack_in=1 -> STREAM, element counter cleared to 1 (ack cycle counts as first element); else counter==TIMEOUT-1 -> DONE with error.
REQ-025 Error takes priority over ack in same cycle.
REQ-026 On ISSUE entry busy_out[addr] SHALL set; on error completion it SHALL clear in DONE cycle.
REQ-027 STREAM: load_en_out=0; count +1 per cycle with load_ack_in=1; on load_ack_in=0 go DONE, error iff count != m*n (product width MBITS+NBITS+2).
REQ-028 DONE: done_valid_out=1 one cycle with done_addr_out, done_error_out; then IDLE; next command may issue earliest the following cycle.
REQ-029 release_in clears busy_out[release_addr_in] next edge; ignored for the register currently in ISSUE/STREAM.
REQ-030 release and a set to the same register in one cycle: set wins.
REQ-031 load_addr/m/n outputs SHALL stay stable from ISSUE entry through DONE.
REQ-032 Dimension legality not checked here; load unit error is authoritative.

Reset
REQ-033 rst low SHALL asynchronously force: state IDLE, FIFO empty, cmd_ready_out=1, load_en_out=0, busy_out=0, done_valid_out=0, done_error_out=0, load/done addr and sizes 0, counters 0.
REQ-034 Reset mid-STREAM SHALL abandon the command with no done pulse; bench drives load unit reset together.

Verification
REQ-035 Push {addr=1,m=2,n=3}; ack high 6 cycles from ISSUE -> done_valid 1 cycle, addr=1, error=0, busy_out[1]=1.
REQ-036 Push {addr=2,m=0,n=3}; load_error_in in ISSUE -> done_error=1, busy_out[2]=0, no STREAM.
REQ-037 Push addr=1 twice without release -> second held in FIFO; release_in addr=1 -> second issues next IDLE cycle.
REQ-038 No ack/error for TIMEOUT=16 cycles -> DONE with error exactly 16 cycles after ISSUE entry.
REQ-039 Push QDEPTH+1 commands back-to-back while first blocked -> cmd_ready_out low after 4, no command lost or duplicated, order preserved.
REQ-040 Ack drops after 5 of m*n=6 elements -> done_error=1; assert rst low mid-STREAM -> all outputs at reset values immediately, no done pulse.
